// File: rtl/reg_bus_arbiter.sv
// rtl/reg_bus_arbiter.sv - two-master round-robin arbiter and sequencer for the register-file slave port
module reg_bus_arbiter #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 8,
    parameter int RD_LATENCY    = 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     m0_req,
    input  logic                     m0_we,
    input  logic [ADDRESS_WIDTH-1:0] m0_address,
    input  logic [DATA_WIDTH-1:0]    m0_write_data,
    output logic                     m0_ack,
    output logic [DATA_WIDTH-1:0]    m0_read_data,
    output logic                     m0_error,
    input  logic                     m1_req,
    input  logic                     m1_we,
    input  logic [ADDRESS_WIDTH-1:0] m1_address,
    input  logic [DATA_WIDTH-1:0]    m1_write_data,
    output logic                     m1_ack,
    output logic [DATA_WIDTH-1:0]    m1_read_data,
    output logic                     m1_error,
    output logic                     cs,
    output logic                     we,
    output logic [ADDRESS_WIDTH-1:0] address,
    output logic [DATA_WIDTH-1:0]    write_data,
    input  logic [DATA_WIDTH-1:0]    read_data,
    input  logic                     error,
    output logic [1:0]               grant,
    output logic                     busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [3:0] LATENCY = 4'(RD_LATENCY);

    state_t     state;
    logic       prio;
    logic [3:0] wait_cnt;
    logic       pick_m1;

    // prio=0 means master 0 wins a tie, prio=1 means master 1 wins
    assign pick_m1 = m1_req && (!m0_req || prio);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= IDLE;
            prio         <= 1'b0;
            wait_cnt     <= '0;
            cs           <= 1'b0;
            we           <= 1'b0;
            address      <= '0;
            write_data   <= '0;
            grant        <= 2'b00;
            busy         <= 1'b0;
            m0_ack       <= 1'b0;
            m0_read_data <= '0;
            m0_error     <= 1'b0;
            m1_ack       <= 1'b0;
            m1_read_data <= '0;
            m1_error     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (m0_req || m1_req) begin
                        grant      <= pick_m1 ? 2'b10 : 2'b01;
                        cs         <= 1'b1;
                        we         <= pick_m1 ? m1_we : m0_we;
                        address    <= pick_m1 ? m1_address : m0_address;
                        write_data <= pick_m1 ? m1_write_data : m0_write_data;
                        busy       <= 1'b1;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    cs       <= 1'b0;
                    we       <= 1'b0;
                    wait_cnt <= 4'd1;
                    state    <= WAIT;
                end
                WAIT: begin
                    if (wait_cnt == LATENCY) begin
                        // response is captured for writes as well so slave errors reach the master
                        if (grant[1]) begin
                            m1_read_data <= read_data;
                            m1_error     <= error;
                            m1_ack       <= 1'b1;
                        end else begin
                            m0_read_data <= read_data;
                            m0_error     <= error;
                            m0_ack       <= 1'b1;
                        end
                        state <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                RESP: begin
                    m0_ack <= 1'b0;
                    m1_ack <= 1'b0;
                    grant  <= 2'b00;
                    busy   <= 1'b0;
                    prio   <= ~grant[1];
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// tb/tb_reg_bus_arbiter.sv - randomized bench for reg_bus_arbiter at read latencies 1 and 4
module tb_reg_bus_arbiter;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   mode = 0;
    int   n_checks = 0;
    int   n_fails = 0;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    for (genvar gi = 0; gi < 2; gi++) begin : g_inst
        localparam int L = (gi == 0) ? 1 : 4;

        logic        req [2];
        logic        wem [2];
        logic [7:0]  ma  [2];
        logic [31:0] mw  [2];
        logic        ack [2];
        logic [31:0] rdm [2];
        logic        errm[2];
        logic        cs_w, we_w, busy_w;
        logic [7:0]  address_w;
        logic [31:0] write_data_w;
        logic [1:0]  grant_w;
        logic [31:0] rd_w = '0;
        logic        err_w = 1'b0;

        reg_bus_arbiter #(.DATA_WIDTH(32), .ADDRESS_WIDTH(8), .RD_LATENCY(L)) u_dut (
            .clk(clk), .reset_n(reset_n),
            .m0_req(req[0]), .m0_we(wem[0]), .m0_address(ma[0]), .m0_write_data(mw[0]),
            .m0_ack(ack[0]), .m0_read_data(rdm[0]), .m0_error(errm[0]),
            .m1_req(req[1]), .m1_we(wem[1]), .m1_address(ma[1]), .m1_write_data(mw[1]),
            .m1_ack(ack[1]), .m1_read_data(rdm[1]), .m1_error(errm[1]),
            .cs(cs_w), .we(we_w), .address(address_w), .write_data(write_data_w),
            .read_data(rd_w), .error(err_w), .grant(grant_w), .busy(busy_w)
        );

        // slave register file: address 0xFF always errors and reads as zero
        logic [31:0] s_mem [256];
        logic [31:0] ref_mem [256];
        logic [31:0] s_rd = '0;
        logic        s_err = 1'b0;
        int          cd = 0;

        initial begin
            for (int i = 0; i < 256; i++) begin
                s_mem[i]   = '0;
                ref_mem[i] = '0;
            end
            for (int i = 0; i < 2; i++) begin
                req[i] = 1'b0; wem[i] = 1'b0; ma[i] = '0; mw[i] = '0;
            end
        end

        always @(posedge clk) begin
            if (cs_w) begin
                s_err = (address_w == 8'hFF);
                s_rd  = (we_w || s_err) ? 32'h0 : s_mem[address_w];
                if (we_w) s_mem[address_w] = write_data_w;
                cd = L;
            end
            if (cd > 0) begin
                cd--;
                #1;
                if (cd == 0) begin
                    rd_w  = s_rd;
                    err_w = s_err;
                end else begin
                    rd_w  = $urandom;
                    err_w = 1'($urandom);
                end
            end
        end

        // masters: random traffic, drain, or a lone master-1 read of 0x10
        logic go;
        always @(negedge clk) begin
            for (int i = 0; i < 2; i++) begin
                go = 1'b0;
                case (mode)
                    0: req[i] = 1'b0;
                    1: begin
                        if (ack[i]) begin
                            if ($urandom_range(3) != 0) go = 1'b1;
                            else req[i] = 1'b0;
                        end else if (!req[i] && $urandom_range(1) == 1) begin
                            go = 1'b1;
                        end
                    end
                    2: begin
                        if (i == 0) req[0] = 1'b0;
                        else if (!req[1] || ack[1]) begin
                            req[1] = 1'b1; wem[1] = 1'b0; ma[1] = 8'h10;
                        end
                    end
                    3: if (!req[i]) go = 1'b1;
                    default: ;
                endcase
                if (go) begin
                    req[i] = 1'b1;
                    wem[i] = 1'($urandom_range(1));
                    mw[i]  = $urandom;
                    case ($urandom_range(5))
                        0: ma[i] = 8'h10;
                        1: ma[i] = 8'h11;
                        2: ma[i] = 8'h12;
                        3: ma[i] = 8'h13;
                        4: ma[i] = 8'hFF;
                        default: ma[i] = 8'($urandom);
                    endcase
                end
            end
        end

        // transaction-level reference: a grant at edge g puts cs in the cycle after g,
        // ack after edge g+1+L, and the arbiter can grant again from edge g+3+L
        int          edge_n = 0, start = -100, free_edge = 0, owner = 0, prio = 0;
        logic        t_we = 1'b0, t_err = 1'b0, in_txn;
        logic [7:0]  t_addr = '0;
        logic [31:0] t_wdata = '0, t_rd = '0;
        logic [31:0] exp_rd [2];
        logic        exp_err[2];
        logic        e_cs = 1'b0, e_we = 1'b0, e_busy = 1'b0, e_ack0 = 1'b0, e_ack1 = 1'b0;
        logic [1:0]  e_grant = 2'b00;
        int          n_txn = 0;

        always @(posedge clk) begin
            edge_n++;
            if (!reset_n) begin
                start = -100; free_edge = 0; prio = 0;
                t_we = 1'b0; t_addr = '0; t_wdata = '0;
                exp_rd[0] = '0; exp_rd[1] = '0; exp_err[0] = 1'b0; exp_err[1] = 1'b0;
            end else begin
                if (edge_n >= free_edge && (req[0] || req[1])) begin
                    owner     = (req[0] && req[1]) ? prio : (req[1] ? 1 : 0);
                    prio      = 1 - owner;
                    start     = edge_n;
                    free_edge = edge_n + 3 + L;
                    t_we      = wem[owner];
                    t_addr    = ma[owner];
                    t_wdata   = mw[owner];
                    t_err     = (t_addr == 8'hFF);
                    t_rd      = (t_we || t_err) ? 32'h0 : ref_mem[t_addr];
                    if (t_we) ref_mem[t_addr] = t_wdata;
                    n_txn++;
                end
                if (edge_n == start + 1 + L) begin
                    exp_rd[owner]  = t_rd;
                    exp_err[owner] = t_err;
                end
            end
            in_txn  = reset_n && edge_n >= start && edge_n <= start + 1 + L;
            e_cs    = reset_n && edge_n == start;
            e_we    = e_cs && t_we;
            e_grant = in_txn ? ((owner == 1) ? 2'b10 : 2'b01) : 2'b00;
            e_busy  = in_txn;
            e_ack0  = reset_n && edge_n == start + 1 + L && owner == 0;
            e_ack1  = reset_n && edge_n == start + 1 + L && owner == 1;
        end

        always @(negedge clk) begin
            if (edge_n > 0) begin
                check($sformatf("L%0d cs", L), cs_w, e_cs);
                check($sformatf("L%0d we", L), we_w, e_we);
                check($sformatf("L%0d address", L), address_w, t_addr);
                check($sformatf("L%0d write_data", L), write_data_w, t_wdata);
                check($sformatf("L%0d grant", L), grant_w, e_grant);
                check($sformatf("L%0d busy", L), busy_w, e_busy);
                check($sformatf("L%0d m0_ack", L), ack[0], e_ack0);
                check($sformatf("L%0d m1_ack", L), ack[1], e_ack1);
                check($sformatf("L%0d m0_read_data", L), rdm[0], exp_rd[0]);
                check($sformatf("L%0d m1_read_data", L), rdm[1], exp_rd[1]);
                check($sformatf("L%0d m0_error", L), errm[0], exp_err[0]);
                check($sformatf("L%0d m1_error", L), errm[1], exp_err[1]);
            end
        end
    end

    int found;
    int served;

    initial begin
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b1;
        @(posedge clk); #2 mode = 3;
        @(posedge clk); #2 mode = 1;
        repeat (1500) @(posedge clk);
        #2 mode = 0;
        repeat (20) @(posedge clk);
        check("traffic L1", 64'(g_inst[0].n_txn > 100), 64'd1);
        check("traffic L4", 64'(g_inst[1].n_txn > 50), 64'd1);
        #2 mode = 2;
        found = 0;
        for (int k = 0; k < 20 && found == 0; k++) begin
            @(negedge clk);
            if (g_inst[0].cs_w) found = 1;
        end
        check("m1 read issued", 64'(found), 64'd1);
        @(posedge clk); #2 reset_n = 1'b0;
        @(posedge clk); #2 reset_n = 1'b1;
        served = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (g_inst[0].ack[1]) served++;
        end
        check("m1 served after reset", 64'(served > 0), 64'd1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
